alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Purpose: button-driven ALU operand/opcode load sequencer (A -> B -> OP -> RES) with hold-off debounce.
// Latency: accepted enter edge -> strobe/state next cycle; update_res one cycle after load_op.
// Backpressure: none; edges inside the hold-off window are dropped. Optional ALU_CTRL_LIVE_EN: update_res held in S_RES.
module alu_seq_ctrl #(
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       back,
    input  logic       clear,
    output logic       load_a,
    output logic       load_b,
    output logic       load_op,
    output logic       update_res,
    output logic [3:0] step_leds,
    output logic [7:0] op_count
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_A, S_B, S_OP, S_RES} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            enter_q;
    logic            back_q;
    logic [CW-1:0]   hold_cnt;
    logic [CW-1:0]   hold_nxt;
    logic            enter_edge;
    logic            back_edge;
    logic            hold_idle;
    logic            take_enter;
    logic            take_back;
    logic            load_a_nxt;
    logic            load_b_nxt;
    logic            load_op_nxt;
    logic            update_nxt;

    always_comb begin
        enter_edge  = enter & ~enter_q;
        back_edge   = back & ~back_q;
        hold_idle   = (hold_cnt == '0);
        // clear wins over enter, enter wins over back; losers are discarded
        take_enter  = ~clear & hold_idle & enter_edge;
        take_back   = ~clear & hold_idle & back_edge & ~enter_edge;

        state_nxt   = state;
        hold_nxt    = hold_cnt;
        load_a_nxt  = 1'b0;
        load_b_nxt  = 1'b0;
        load_op_nxt = 1'b0;

        if (clear) begin
            state_nxt = S_A;
            hold_nxt  = '0;
        end else if (take_enter) begin
            hold_nxt = HOLD_LOAD;
            case (state)
                S_A: begin
                    load_a_nxt = 1'b1;
                    state_nxt  = S_B;
                end
                S_B: begin
                    load_b_nxt = 1'b1;
                    state_nxt  = S_OP;
                end
                S_OP: begin
                    load_op_nxt = 1'b1;
                    state_nxt   = S_RES;
                end
                S_RES: state_nxt = S_A;
            endcase
        end else if (take_back) begin
            hold_nxt = HOLD_LOAD;
            case (state)
                S_A:   state_nxt = S_A;
                S_B:   state_nxt = S_A;
                S_OP:  state_nxt = S_B;
                S_RES: state_nxt = S_OP;
            endcase
        end else if (!hold_idle) begin
            hold_nxt = hold_cnt - CW'(1);
        end

`ifdef ALU_CTRL_LIVE_EN
        // Live tracking starts once the opcode register has settled (cycle after load_op)
        update_nxt = ~clear & (state_nxt == S_RES) & ~load_op_nxt;
`else
        update_nxt = ~clear & load_op;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_A;
            hold_cnt   <= '0;
            enter_q    <= 1'b1;
            back_q     <= 1'b1;
            load_a     <= 1'b0;
            load_b     <= 1'b0;
            load_op    <= 1'b0;
            update_res <= 1'b0;
            step_leds  <= 4'b0001;
            op_count   <= 8'd0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            enter_q    <= enter;
            back_q     <= back;
            load_a     <= load_a_nxt;
            load_b     <= load_b_nxt;
            load_op    <= load_op_nxt;
            update_res <= update_nxt;
            step_leds  <= 4'b0001 << state_nxt;
            op_count   <= op_count + 8'(update_nxt & ~update_res);
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed scenarios plus random buttons against a behavioural model.
module tb_alu_seq_ctrl;

    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enter = 1'b0;
    logic       back = 1'b0;
    logic       clear = 1'b0;
    logic       load_a;
    logic       load_b;
    logic       load_op;
    logic       update_res;
    logic [3:0] step_leds;
    logic [7:0] op_count;

    alu_seq_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enter      (enter),
        .back       (back),
        .clear      (clear),
        .load_a     (load_a),
        .load_b     (load_b),
        .load_op    (load_op),
        .update_res (update_res),
        .step_leds  (step_leds),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: stage 0..3 = A, B, OP, RES
    int m_stage = 0;
    int m_hold  = 0;
    int m_cnt   = 0;
    bit m_la = 0, m_lb = 0, m_lo = 0, m_up = 0;
    bit m_pe = 1, m_pb = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit e, b, lo_old, up_old;
        if (!reset) begin
            m_stage = 0; m_hold = 0; m_cnt = 0;
            m_la = 0; m_lb = 0; m_lo = 0; m_up = 0;
            m_pe = 1; m_pb = 1;
            return;
        end
        e = enter && !m_pe;
        b = back && !m_pb;
        lo_old = m_lo;
        up_old = m_up;
        m_la = 0; m_lb = 0; m_lo = 0;
        if (clear) begin
            m_stage = 0;
            m_hold  = 0;
        end else if (m_hold == 0 && (e || b)) begin
            m_hold = HOLD - 1;
            if (e) begin
                if (m_stage == 0) m_la = 1;
                if (m_stage == 1) m_lb = 1;
                if (m_stage == 2) m_lo = 1;
                m_stage = (m_stage + 1) % 4;
            end else if (m_stage > 0) begin
                m_stage = m_stage - 1;
            end
        end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
        end
`ifdef ALU_CTRL_LIVE_EN
        m_up = !clear && m_stage == 3 && !m_lo;
`else
        m_up = !clear && lo_old;
`endif
        if (m_up && !up_old) m_cnt = (m_cnt + 1) % 256;
        m_pe = enter;
        m_pb = back;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("step_leds", 32'(step_leds), 32'(1 << m_stage));
        check("load_a", 32'(load_a), 32'(m_la));
        check("load_b", 32'(load_b), 32'(m_lb));
        check("load_op", 32'(load_op), 32'(m_lo));
        check("update_res", 32'(update_res), 32'(m_up));
        check("op_count", 32'(op_count), 32'(m_cnt));
        check("strobe_excl", 32'(int'(load_a) + int'(load_b) + int'(load_op) + int'(update_res) <= 1), 32'd1);
    endtask

    task automatic press_enter(input int gap);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic press_back(input int gap);
        back = 1'b1;
        tick();
        back = 1'b0;
        repeat (gap - 1) tick();
    endtask

    initial begin
        int ups;
        logic [7:0] cnt0;

        reset = 1'b0;
        repeat (3) tick();
        check("rst_leds", 32'(step_leds), 32'h1);
        check("rst_count", 32'(op_count), 32'h0);
        reset = 1'b1;
        tick();

        // Full sequence to S_RES
        repeat (3) press_enter(20);
        check("seq_leds", 32'(step_leds), 32'h8);
        check("seq_count", 32'(op_count), 32'h1);
        press_enter(20);
        check("seq_wrap_leds", 32'(step_leds), 32'h1);

        // Second edge inside hold-off is dropped
        press_enter(5);
        press_enter(20);
        check("holdoff_leds", 32'(step_leds), 32'h2);
        press_enter(20);
        check("holdoff_next", 32'(step_leds), 32'h4);

        // Back from S_RES, then enter again
        press_enter(20);
        press_back(20);
        check("back_leds", 32'(step_leds), 32'h4);
        press_enter(20);
        check("back_count", 32'(op_count), 32'h3);

        // Enter and clear together in S_OP
        clear = 1'b1; tick(); clear = 1'b0; tick();
        repeat (2) press_enter(20);
        cnt0 = op_count;
        enter = 1'b1; clear = 1'b1; tick();
        enter = 1'b0; clear = 1'b0;
        repeat (20) tick();
        check("clr_enter_leds", 32'(step_leds), 32'h1);
        check("clr_enter_cnt", 32'(op_count), 32'(cnt0));

        // Clear in the cycle after load_op
        repeat (2) press_enter(20);
        enter = 1'b1; tick();
        enter = 1'b0; clear = 1'b1; tick();
        clear = 1'b0;
        repeat (20) tick();
        check("clr_after_op", 32'(op_count), 32'(cnt0));

        // Enter held across reset release
        enter = 1'b1; reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();
        check("held_enter", 32'(step_leds), 32'h1);
        enter = 1'b0;
        tick();

        // 256 operations wrap op_count
        repeat (256) repeat (4) press_enter(20);
        check("count_wrap", 32'(op_count), 32'h0);

        // Dwell in S_RES
        repeat (2) press_enter(20);
        enter = 1'b1; tick(); enter = 1'b0;
        ups = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ups += int'(update_res);
        end
`ifdef ALU_CTRL_LIVE_EN
        check("live_ups", 32'(ups), 32'd10);
`else
        check("pulse_ups", 32'(ups), 32'd1);
`endif
        check("dwell_count", 32'(op_count), 32'h1);

        // Random buttons
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 7) == 0) enter = ~enter;
            if ($urandom_range(0, 15) == 0) back = ~back;
            clear = ($urandom_range(0, 63) == 0);
            reset = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
